// File: rtl/bt_uart_tx_pkg.sv
// Shared UART definitions for the Bluetooth link.
// The Rx side imports the same clock and baud defaults, so both ends agree on bit timing.
package bt_uart_tx_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        STOP_LEVEL = 1'b1;
  localparam logic        IDLE_LEVEL = 1'b1;

  localparam int unsigned DEFAULT_CLK_HZ = 16000000;
  localparam int unsigned DEFAULT_BAUD   = 9600;

endpackage

// File: rtl/bt_uart_tx_if.sv
// Byte producer handshake into the UART transmitter.
interface bt_uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/bt_uart_tx_byte_fifo.sv
// Parameterized synchronous circular FIFO with async active-low reset.
// Pushes while full and pops while empty are ignored.
module byte_fifo #(
  parameter  int unsigned Width  = 8,
  parameter  int unsigned Depth  = 4,
  localparam int unsigned AddrW  = $clog2(Depth),
  localparam int unsigned CountW = AddrW + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [Width-1:0]  i_wdata,
  input  logic              i_pop,
  output logic [Width-1:0]  o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic [CountW-1:0] o_count
);

  logic [Width-1:0]  r_mem [Depth];
  logic [AddrW-1:0]  r_wr_ptr;
  logic [AddrW-1:0]  r_rd_ptr;
  logic [CountW-1:0] r_count;
  logic              w_push;
  logic              w_pop;

  always_comb begin
    o_full  = (r_count == CountW'(Depth));
    o_empty = (r_count == '0);
    o_count = r_count;
    o_rdata = r_mem[r_rd_ptr];
    w_push  = i_push && !o_full;
    w_pop   = i_pop && !o_empty;
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AddrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AddrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CountW'(1);
        2'b01:   r_count <= r_count - CountW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bt_uart_tx.sv
// UART 8N1 transmitter feeding the Bluetooth module's Rx line.
// Bytes are queued in a small FIFO and serialized LSB-first; stop and next start abut.
module bt_uart_tx
  import bt_uart_tx_pkg::*;
#(
  parameter  int unsigned CLK_HZ       = DEFAULT_CLK_HZ,
  parameter  int unsigned BAUD         = DEFAULT_BAUD,
  parameter  int unsigned FIFO_DEPTH   = 4,
  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD,
  localparam int unsigned CntW         = $clog2(CLKS_PER_BIT),
  localparam int unsigned CountW       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              WF_CLK,
  input  logic              WF_BUTTON,
  bt_uart_tx_if.slave       bus,
  output logic              Tx,
  output logic              busy,
  output logic [CountW-1:0] fifo_count
);

  tx_state_e        r_state, w_state_d;
  logic [CntW-1:0]  r_bit_cnt, w_bit_cnt_d;
  logic [2:0]       r_idx, w_idx_d;
  logic [7:0]       r_shift, w_shift_d;
  logic             r_tx, w_tx_d;
  logic             w_push, w_pop, w_full, w_empty, w_bit_end;
  logic [7:0]       w_fifo_rdata;

  byte_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (WF_CLK),
    .i_rst_n (WF_BUTTON),
    .i_push  (w_push),
    .i_wdata (bus.tx_data),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  assign w_bit_end = (r_bit_cnt == CntW'(CLKS_PER_BIT - 1));

  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      r_state   <= TX_IDLE;
      r_bit_cnt <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_tx      <= IDLE_LEVEL;
    end else begin
      r_state   <= w_state_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_idx     <= w_idx_d;
      r_shift   <= w_shift_d;
      r_tx      <= w_tx_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_bit_cnt_d = r_bit_cnt + CntW'(1);
    w_idx_d     = r_idx;
    w_shift_d   = r_shift;
    w_tx_d      = r_tx;
    case (r_state)
      TX_IDLE: begin
        w_bit_cnt_d = '0;
        w_tx_d      = IDLE_LEVEL;
        if (!w_empty) begin
          w_shift_d = w_fifo_rdata;
          w_tx_d    = 1'b0;
          w_state_d = TX_START;
        end
      end
      TX_START: begin
        if (w_bit_end) begin
          w_bit_cnt_d = '0;
          w_tx_d      = r_shift[0];
          w_idx_d     = '0;
          w_state_d   = TX_DATA;
        end
      end
      TX_DATA: begin
        if (w_bit_end) begin
          w_bit_cnt_d = '0;
          if (r_idx == 3'(DATA_BITS - 1)) begin
            w_tx_d    = STOP_LEVEL;
            w_state_d = TX_STOP;
          end else begin
            w_shift_d = {1'b0, r_shift[7:1]};
            w_tx_d    = r_shift[1];
            w_idx_d   = r_idx + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (w_bit_end) begin
          w_bit_cnt_d = '0;
          // Chain straight into the next start bit when more bytes wait.
          if (!w_empty) begin
            w_shift_d = w_fifo_rdata;
            w_tx_d    = 1'b0;
            w_state_d = TX_START;
          end else begin
            w_tx_d    = IDLE_LEVEL;
            w_state_d = TX_IDLE;
          end
        end
      end
      default: begin
        w_bit_cnt_d = '0;
        w_tx_d      = IDLE_LEVEL;
        w_state_d   = TX_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.tx_ready = !w_full;
    w_push       = bus.tx_valid && !w_full;
    w_pop        = !w_empty && ((r_state == TX_IDLE) || ((r_state == TX_STOP) && w_bit_end));
    busy         = (r_state != TX_IDLE) || (fifo_count != '0);
    Tx           = r_tx;
  end

endmodule

// File: tb/tb_bt_uart_tx.sv
// Bench for bt_uart_tx: per-cycle line/occupancy reference model plus an independent UART decoder.
module tb_bt_uart_tx;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bt_uart_tx_if bus ();
  bt_uart_tx_if bus2 ();

  logic       tx, busy, tx2, busy2;
  logic [2:0] cnt, cnt2;

  bt_uart_tx #(.CLK_HZ(160), .BAUD(10), .FIFO_DEPTH(DEPTH)) dut (
    .WF_CLK     (clk),
    .WF_BUTTON  (rst_n),
    .bus        (bus),
    .Tx         (tx),
    .busy       (busy),
    .fifo_count (cnt)
  );

  bt_uart_tx dut2 (
    .WF_CLK     (clk),
    .WF_BUTTON  (rst_n),
    .bus        (bus2),
    .Tx         (tx2),
    .busy       (busy2),
    .fifo_count (cnt2)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: queue of waiting bytes plus the frame currently on the line.
  logic [7:0] m_q[$];
  bit         m_active = 1'b0;
  int         m_start = 0;
  logic [7:0] m_byte = 8'h00;

  logic [7:0] sent_q[$];
  logic [7:0] dec_q[$];
  bit         d_on = 1'b0;
  int         d_start = 0;
  logic [7:0] d_shift = 8'h00;
  logic       prev_tx = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic model_line();
    int k;
    if (!m_active) return 1'b1;
    k = (cyc - m_start) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_active = 1'b0;
    sent_q.delete();
    dec_q.delete();
    d_on = 1'b0;
    prev_tx = 1'b1;
  endtask

  task automatic tick(output bit acc);
    logic [7:0] d;
    int off, k;
    acc = bus.tx_valid && (m_q.size() < DEPTH) && rst_n;
    d = bus.tx_data;
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      if (m_active && (cyc - m_start == FRAME)) m_active = 1'b0;
      if (!m_active && m_q.size() != 0) begin
        m_byte   = m_q.pop_front();
        m_active = 1'b1;
        m_start  = cyc;
      end
      if (acc) begin
        m_q.push_back(d);
        sent_q.push_back(d);
      end
    end
    #1;
    check_eq("line", tx, model_line());
    check_eq("count", cnt, m_q.size());
    check_eq("busy", busy, m_active || m_q.size() != 0);
    check_eq("ready", bus.tx_ready, m_q.size() < DEPTH);
    if (!d_on && prev_tx && !tx) begin
      d_on = 1'b1;
      d_start = cyc;
    end else if (d_on) begin
      off = cyc - d_start;
      if (off % CPB == CPB / 2) begin
        k = off / CPB;
        if (k == 0) check_eq("dec_start", tx, 1'b0);
        else if (k <= 8) d_shift[k-1] = tx;
        else begin
          check_eq("dec_stop", tx, 1'b1);
          dec_q.push_back(d_shift);
          d_on = 1'b0;
        end
      end
    end
    prev_tx = tx;
  endtask

  task automatic run(input int n);
    bit a;
    repeat (n) tick(a);
  endtask

  task automatic push_n(input logic [7:0] first, input int n);
    bit a;
    int got = 0;
    int guard = 0;
    bus.tx_valid = 1'b1;
    bus.tx_data  = first;
    while (got < n && guard < 3000) begin
      tick(a);
      guard++;
      if (a) begin
        got++;
        bus.tx_data = first + 8'(got);
        if (n == 6 && got == 5) begin
          check_eq("t3_full_ready", bus.tx_ready, 1'b0);
          check_eq("t3_full_count", cnt, 3'd4);
        end
      end
    end
    bus.tx_valid = 1'b0;
    check_eq("push_accepted", got, n);
  endtask

  task automatic drain();
    int n = 0;
    while ((m_active || m_q.size() != 0) && n < 4000) begin
      run(1);
      n++;
    end
    run(2);
  endtask

  task automatic check_decoded(input string tag);
    int n;
    check_eq({tag, "_n"}, dec_q.size(), sent_q.size());
    n = (dec_q.size() < sent_q.size()) ? dec_q.size() : sent_q.size();
    for (int i = 0; i < n; i++) check_eq(tag, dec_q[i], sent_q[i]);
    dec_q.delete();
    sent_q.delete();
  endtask

  initial begin
    bit a;
    int n, rise, guard;
    bus.tx_valid  = 1'b0;
    bus.tx_data   = 8'h00;
    bus2.tx_valid = 1'b0;
    bus2.tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_count", cnt, 3'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ready", bus.tx_ready, 1'b1);
    rst_n = 1'b1;
    cyc = 0;

    // Single byte pushed at cycle 10.
    run(9);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h55;
    tick(a);
    bus.tx_valid = 1'b0;
    tick(a);
    check_eq("t1_fall", tx, 1'b0);
    run(159);
    check_eq("t1_stop_tx", tx, 1'b1);
    check_eq("t1_busy_170", busy, 1'b1);
    tick(a);
    check_eq("t1_busy_171", busy, 1'b0);
    check_eq("t1_idle_171", tx, 1'b1);
    check_decoded("t1_dec");

    push_n(8'hA5, 1);
    drain();
    check_decoded("t2_dec");

    push_n(8'h01, 6);
    drain();
    check_decoded("t3_dec");

    // Push landing exactly on a stop-end pop edge.
    push_n(8'h21, 3);
    guard = 0;
    while (cyc != m_start + FRAME - 1 && guard < 400) begin
      tick(a);
      guard++;
    end
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h44;
    tick(a);
    bus.tx_valid = 1'b0;
    check_eq("t4_count", cnt, 3'd2);
    drain();
    check_decoded("t4_dec");

    // Reset during data bit 3 with two bytes queued.
    push_n(8'h31, 3);
    guard = 0;
    while (!(m_active && (cyc - m_start == 4 * CPB + 3)) && guard < 400) begin
      tick(a);
      guard++;
    end
    rst_n = 1'b0;
    #1;
    check_eq("t5_tx", tx, 1'b1);
    check_eq("t5_count", cnt, 3'd0);
    check_eq("t5_busy", busy, 1'b0);
    check_eq("t5_ready", bus.tx_ready, 1'b1);
    model_reset();
    run(3);
    #2;
    rst_n = 1'b1;
    run(50);
    check_eq("t5_idle", tx, 1'b1);
    check_decoded("t5_dec");

    // Random producer with hold-until-accepted behaviour.
    for (int i = 0; i < 1200; i++) begin
      if (!bus.tx_valid && $urandom_range(0, 19) == 0) begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'($urandom);
      end
      tick(a);
      if (a) bus.tx_valid = 1'b0;
    end
    bus.tx_valid = 1'b0;
    drain();
    check_decoded("rand_dec");

    // Default timing: 1666 clocks per bit.
    bus2.tx_data  = 8'h00;
    bus2.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus2.tx_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t6_fall", tx2, 1'b0);
    n = 0;
    rise = -1;
    while (busy2 && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
      if (tx2 && rise < 0) rise = n;
    end
    check_eq("t6_low", rise, 14994);
    check_eq("t6_len", n, 16660);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bt_uart_tx.md
Name: bt_uart_tx

Overview:
UART 8N1 transmitter that drives the Bluetooth module's Rx line. Default timing is 9600 baud from the 16 MHz WF_CLK. It is the send-side counterpart of the Bluetooth receive path. It accepts bytes over a valid/ready handshake into a small FIFO and serializes them LSB-first. The top level maps its Tx output onto the ir_snsrch1 pin.

Parameters:
- CLK_HZ, 16000000, input clock frequency in Hz.
- BAUD, 9600, line rate in bit/s. CLKS_PER_BIT = CLK_HZ / BAUD, integer truncation (1666 at defaults). Must be >= 2.
- FIFO_DEPTH, 4, byte FIFO entries. Must be a power of two, >= 2.

Ports:
- WF_CLK  in  1  system clock; all logic on the rising edge.
- WF_BUTTON  in  1  asynchronous active-low reset.
- tx_data  in  8  byte to send; sampled when tx_valid && tx_ready.
- tx_valid  in  1  producer offers tx_data.
- tx_ready  out  1  FIFO can accept; equals !full.
- Tx  out  1  serial line, idle high, registered.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (WF_BUTTON low, asynchronous):
  - Tx=1, tx_ready=1, busy=0, fifo_count=0.
  - FIFO pointers are cleared and the FSM goes to IDLE.
  - Asserting reset mid-frame aborts the frame immediately: Tx goes high with no stop-bit completion, and queued bytes are discarded.
- Handshake:
  - A push occurs on an edge where tx_valid && tx_ready.
  - tx_ready is combinational !full and never depends on tx_valid.
  - tx_valid while full is ignored; no byte is lost from the FIFO and the producer must hold.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - Push and pop on the same edge leave the count unchanged.
  - A pop happens only when the FSM loads the shift register.
- FSM states: IDLE, START, DATA, STOP. There is one bit counter bit_cnt (0..CLKS_PER_BIT-1) and one index counter idx (0..7).
  - IDLE: Tx=1. If the FIFO is non-empty: pop into shift register, drive Tx=0, go to START, clear bit_cnt. A byte pushed into an empty FIFO at edge k puts the falling start edge on Tx at edge k+1.
  - START: hold for CLKS_PER_BIT cycles. Then Tx=shift[0], idx=0, go to DATA.
  - DATA: each bit is held for CLKS_PER_BIT cycles, LSB first. After bit 7, Tx=1 and go to STOP.
  - STOP: hold Tx=1 for CLKS_PER_BIT cycles. At the end:
    - if the FIFO is non-empty, pop, set Tx=0 and go directly to START (back-to-back frames, zero idle gap);
    - otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles, from the Tx falling edge to the end of the stop bit.
- busy = (state != IDLE) || (fifo_count != 0).
- Tx changes only on clock edges and is glitch-free, driven directly from a flop.

Decomposition:
- Shared package/header holds:
  - FSM state encodings TX_IDLE/TX_START/TX_DATA/TX_STOP (2 bits);
  - UART frame constants: DATA_BITS=8, STOP_LEVEL=1, IDLE_LEVEL=1;
  - default CLK_HZ/BAUD, shared with the Rx side so both ends agree.
- One sub-module: byte_fifo, a parameterized synchronous FIFO with push/pop/full/empty/count and async active-low reset. The Rx path can reuse it later.
- The serializer FSM lives in bt_uart_tx.

Test Plan:
Simulation uses CLK_HZ=160, BAUD=10, so CLKS_PER_BIT=16.
1. Single byte 0x55 pushed at cycle 10 into an idle block:
   - Tx falls at cycle 11;
   - line reads 0,1,0,1,0,1,0,1,0,1, each level held 16 cycles;
   - Tx is high from cycle 171 onward and busy drops at cycle 171.
2. Bit order, push 0xA5: sampled data bits are 1,0,1,0,0,1,0,1 (LSB first), and a reference UART decoder recovers 0xA5.
3. Burst of 6 bytes 0x01..0x06 with tx_valid held high:
   - 1 byte is accepted into the FSM and 4 are queued;
   - tx_ready=0 with fifo_count=4 until the first pop;
   - all 6 frames go out back-to-back with no idle cycles between stop and start;
   - the decoded order matches.
4. Simultaneous push and pop, with fifo_count=2 at a STOP-end edge plus a push: fifo_count stays 2 and the byte is neither lost nor duplicated.
5. Reset mid-frame: pull WF_BUTTON low during DATA bit 3 with 2 bytes queued.
   - Tx=1, fifo_count=0, busy=0 and tx_ready=1 immediately, with no clock needed.
   - After release the line stays idle until a new push.
6. Default parameters (16 MHz, 9600): one frame of 0x00 spans exactly 16660 cycles from the start edge to the end of the stop bit.
